// File: rtl/trellis_io.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trellis_io : parameterised tristate pad cell (INPUT / OUTPUT / BIDIR) with |
// |              optional output-side (I,T) and input-side (O) registers.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module trellis_io #(
  parameter string DIR     = "BIDIR",
  parameter int    WIDTH   = 8,
  parameter bit    REG_OUT = 1'b0,
  parameter bit    REG_IN  = 1'b0
) (
  input  logic             fifo_clk_i,
  input  logic             reset_n_i,
  inout  wire  [WIDTH-1:0] B,
  input  logic             T,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             drv_o
);

  localparam bit c_is_input  = (DIR == "INPUT");
  localparam bit c_is_output = (DIR == "OUTPUT");
  localparam bit c_is_bidir  = (DIR == "BIDIR");

  logic             t_eff;
  logic [WIDTH-1:0] i_eff;

  generate
    if (REG_OUT) begin : g_reg_out
      logic             t_d, t_q;
      logic [WIDTH-1:0] i_d, i_q;
      assign t_d = T;
      assign i_d = I;
      // Enable and data share one register stage so they can never skew.
      always_ff @(posedge fifo_clk_i) begin
        if (!reset_n_i) begin
          t_q <= 1'b1;
          i_q <= '0;
        end else begin
          t_q <= t_d;
          i_q <= i_d;
        end
      end
      assign t_eff = t_q;
      assign i_eff = i_q;
    end else begin : g_comb_out
      assign t_eff = T;
      assign i_eff = I;
    end
  endgenerate

  generate
    if (c_is_bidir) begin : g_bidir
      assign B     = t_eff ? {WIDTH{1'bz}} : i_eff;
      assign drv_o = ~t_eff;
    end else if (c_is_output) begin : g_output
      assign B     = i_eff;
      assign drv_o = 1'b1;
    end else if (c_is_input) begin : g_input
      assign drv_o = 1'b0;
    end else begin : g_bad_dir
      $error("trellis_io: DIR must be \"INPUT\", \"OUTPUT\" or \"BIDIR\"");
      assign drv_o = 1'b0;
    end
  endgenerate

  generate
    if (c_is_output) begin : g_o_const
      assign O = '0;
    end else if (REG_IN) begin : g_reg_in
      logic [WIDTH-1:0] o_d, o_q;
      assign o_d = B;
      always_ff @(posedge fifo_clk_i) begin
        if (!reset_n_i) begin
          o_q <= '0;
        end else begin
          o_q <= o_d;
        end
      end
      assign O = o_q;
    end else begin : g_comb_in
      // Loopback: in BIDIR the pad is read even while this cell drives it.
      assign O = B;
    end
  endgenerate

  // Some inputs are intentionally ignored in certain modes.
  logic unused_sink;
  assign unused_sink = ^{fifo_clk_i, reset_n_i, T, I, t_eff, i_eff, B};

endmodule
`default_nettype wire

// File: tb/tb_trellis_io.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trellis_io : directed self-checking bench for trellis_io in BIDIR       |
// |                 (comb and registered), INPUT and OUTPUT configurations.    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_trellis_io;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t_in;
  logic [7:0] i_in;

  logic       ext_comb_en, ext_reg_en, ext_in_en;
  logic [7:0] ext_comb_val, ext_reg_val, ext_in_val;

  wire  [7:0] pad_comb, pad_reg, pad_in, pad_out;
  logic [7:0] o_comb, o_reg, o_in, o_out;
  logic       drv_comb, drv_reg, drv_in, drv_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External drivers model the far side of each pad.
  assign pad_comb = ext_comb_en ? ext_comb_val : 8'hzz;
  assign pad_reg  = ext_reg_en  ? ext_reg_val  : 8'hzz;
  assign pad_in   = ext_in_en   ? ext_in_val   : 8'hzz;

  trellis_io #(.DIR("BIDIR"), .WIDTH(8), .REG_OUT(1'b0), .REG_IN(1'b0)) u_comb (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(pad_comb), .T(t_in), .I(i_in),
    .O(o_comb), .drv_o(drv_comb));

  trellis_io #(.DIR("BIDIR"), .WIDTH(8), .REG_OUT(1'b1), .REG_IN(1'b1)) u_reg (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(pad_reg), .T(t_in), .I(i_in),
    .O(o_reg), .drv_o(drv_reg));

  trellis_io #(.DIR("INPUT"), .WIDTH(8), .REG_OUT(1'b0), .REG_IN(1'b0)) u_in (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(pad_in), .T(t_in), .I(i_in),
    .O(o_in), .drv_o(drv_in));

  trellis_io #(.DIR("OUTPUT"), .WIDTH(8), .REG_OUT(1'b0), .REG_IN(1'b0)) u_out (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(pad_out), .T(t_in), .I(i_in),
    .O(o_out), .drv_o(drv_out));

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; t_in = 1'b1; i_in = 8'h00;
    ext_comb_en = 1'b0; ext_reg_en = 1'b0; ext_in_en = 1'b0;
    ext_comb_val = 8'h00; ext_reg_val = 8'h00; ext_in_val = 8'h00;

    tick(); tick();
    check("rst_drv",  {7'd0, drv_reg}, 8'h00);
    check("rst_o",    o_reg, 8'h00);

    // Combinational BIDIR: drive then turn around to an external driver.
    t_in = 1'b0; i_in = 8'hA5; #1;
    check("comb_drv_b",   pad_comb, 8'hA5);
    check("comb_drv_o",   o_comb, 8'hA5);
    check("comb_drv_en",  {7'd0, drv_comb}, 8'h01);
    t_in = 1'b1; ext_comb_en = 1'b1; ext_comb_val = 8'h3C; #1;
    check("comb_rel_b",   pad_comb, 8'h3C);
    check("comb_rel_o",   o_comb, 8'h3C);
    check("comb_rel_en",  {7'd0, drv_comb}, 8'h00);

    // Registered BIDIR: release reset, pad held released.
    rst_n = 1'b1; ext_reg_en = 1'b1; ext_reg_val = 8'h11;
    tick();
    check("reg_idle_en",  {7'd0, drv_reg}, 8'h00);
    check("reg_idle_b",   pad_reg, 8'h11);
    // T falls mid-cycle; drive appears only after the next edge.
    t_in = 1'b0; i_in = 8'h5A; ext_reg_en = 1'b0; #3;
    check("reg_lat_en",   {7'd0, drv_reg}, 8'h00);
    tick();
    check("reg_drv_b",    pad_reg, 8'h5A);
    check("reg_drv_en",   {7'd0, drv_reg}, 8'h01);
    tick();
    check("reg_loop_o",   o_reg, 8'h5A);

    // Registered input sampling.
    t_in = 1'b1;
    tick();
    ext_reg_en = 1'b1; ext_reg_val = 8'h00;
    tick();
    check("regin_o0",     o_reg, 8'h00);
    ext_reg_val = 8'hFF; #2;
    check("regin_hold_o", o_reg, 8'h00);
    check("regin_b",      pad_reg, 8'hFF);
    tick();
    check("regin_o1",     o_reg, 8'hFF);

    // Reset while driving releases the pad at the edge.
    ext_reg_en = 1'b0; t_in = 1'b0; i_in = 8'h77;
    tick();
    check("mid_drv_b",    pad_reg, 8'h77);
    check("mid_drv_en",   {7'd0, drv_reg}, 8'h01);
    tick();
    check("mid_loop_o",   o_reg, 8'h77);
    rst_n = 1'b0;
    tick();
    ext_reg_en = 1'b1; ext_reg_val = 8'h08; #1;
    check("mid_rst_b",    pad_reg, 8'h08);
    check("mid_rst_o",    o_reg, 8'h00);
    check("mid_rst_en",   {7'd0, drv_reg}, 8'h00);
    rst_n = 1'b1; ext_reg_en = 1'b0;
    tick();
    check("mid_rel_b",    pad_reg, 8'h77);
    check("mid_rel_en",   {7'd0, drv_reg}, 8'h01);

    // INPUT: never drives, I/T ignored.
    t_in = 1'b0; i_in = 8'hFF; ext_in_en = 1'b1; ext_in_val = 8'h12; #1;
    check("in_b",         pad_in, 8'h12);
    check("in_o",         o_in, 8'h12);
    check("in_en",        {7'd0, drv_in}, 8'h00);

    // OUTPUT: always drives, T ignored, O tied low.
    t_in = 1'b1; i_in = 8'hC3; #1;
    check("out_b",        pad_out, 8'hC3);
    check("out_en",       {7'd0, drv_out}, 8'h01);
    check("out_o",        o_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
